// File: rtl/menu_nav_overlay.sv
// -----------------------------------------------------------------------------
// menu_nav_overlay
//
// Keyboard-driven multi-page menu controller with a selection-pointer overlay
// on the VGA timing/RGB stream. Sits after the menu background/text stages and
// before the top-level rgb mux.
//
// Navigation:
//   - up/down move the current item (wrap or clamp, modulo N_ITEMS), with
//     auto-repeat while held (first repeat and period = REPEAT_CYC cycles).
//   - enter on the main page (page 0) opens sub-page item+1 when it exists,
//     otherwise raises a selection. Enter on the last item of a sub-page
//     returns to the main page with the cursor on that sub-page's entry;
//     enter on any other sub-page item raises a selection.
//   - A selection is held on sel_valid/sel_page/sel_item until sel_ready.
//   - back_to_main_menu_flag overrides everything and returns to page 0 item 0.
//
// Overlay:
//   - The displayed pointer item is resampled only on the rising edge of
//     vblnk_in, so the pointer never moves mid-frame.
//   - Two-stage pipeline: all stream outputs lag their inputs by 2 clocks.
//
// Ports:
//   clk, rst                 pixel clock, asynchronous active-low reset
//   hcount_in/vcount_in      11-bit pixel / line counters
//   hsync_in/vsync_in        sync pulses
//   hblnk_in/vblnk_in        blanking
//   rgb_in                   12-bit upstream pixel colour
//   keyboard_in              [0]=up [1]=down [2]=enter (levels, clk-synchronous)
//   back_to_main_menu_flag   force page 0 / item 0
//   *_out                    stream outputs, 2-clock latency
//   menu_page/menu_item      current page / item
//   sel_valid/sel_page/sel_item, sel_ready   selection handshake
// -----------------------------------------------------------------------------
module menu_nav_overlay #(
    parameter int          N_PAGES    = 4,
    parameter int          N_ITEMS    = 4,
    parameter int          WRAP       = 1,
    parameter int          REPEAT_CYC = 6_500_000,
    parameter int          PTR_X0     = 100,
    parameter int          PTR_Y0     = 200,
    parameter int          PTR_DY     = 64,
    parameter int          PTR_W      = 16,
    parameter int          PTR_H      = 16,
    parameter logic [11:0] PTR_RGB    = 12'hF00,
    // Derived widths; leave at their defaults.
    parameter int          IW         = $clog2(N_ITEMS),
    parameter int          PW         = (N_PAGES > 1) ? $clog2(N_PAGES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [10:0]   hcount_in,
    input  logic [10:0]   vcount_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          hblnk_in,
    input  logic          vblnk_in,
    input  logic [11:0]   rgb_in,
    input  logic [2:0]    keyboard_in,
    input  logic          back_to_main_menu_flag,
    input  logic          sel_ready,
    output logic [10:0]   hcount_out,
    output logic [10:0]   vcount_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          hblnk_out,
    output logic          vblnk_out,
    output logic [11:0]   rgb_out,
    output logic [PW-1:0] menu_page,
    output logic [IW-1:0] menu_item,
    output logic          sel_valid,
    output logic [PW-1:0] sel_page,
    output logic [IW-1:0] sel_item
);

    localparam int CW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

    typedef enum logic [0:0] {
        ST_IDLE        = 1'b0,
        ST_SELECT_WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Key edge detection and auto-repeat
    // ------------------------------------------------------------------------
    logic [2:0]    r_key_prev;
    logic [CW-1:0] r_rep_cnt;
    logic [2:0]    w_key_rise;
    logic          w_held_ud;
    logic          w_rise_ud;
    logic          w_rep_fire;
    logic          w_ev_up;
    logic          w_ev_dn;
    logic          w_ev_ent;

    assign w_key_rise = keyboard_in & ~r_key_prev;
    assign w_held_ud  = keyboard_in[0] | keyboard_in[1];
    assign w_rise_ud  = w_key_rise[0] | w_key_rise[1];
    // A fresh up/down press restarts the repeat interval, so the first repeat
    // lands REPEAT_CYC cycles after the press itself.
    assign w_rep_fire = w_held_ud && !w_rise_ud && (r_rep_cnt == CW'(REPEAT_CYC - 1));
    assign w_ev_up    = w_key_rise[0] | (w_rep_fire & keyboard_in[0]);
    assign w_ev_dn    = w_key_rise[1] | (w_rep_fire & keyboard_in[1]);
    assign w_ev_ent   = w_key_rise[2];

    // NOTE: clocked state is written with non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop regardless of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_prev <= '0;
            r_rep_cnt  <= '0;
        end else begin
            r_key_prev <= keyboard_in;
            if (!w_held_ud || w_rise_ud || w_rep_fire)
                r_rep_cnt <= '0;
            else
                r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Menu FSM
    // ------------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_page;
    logic [PW-1:0] w_page_nxt;
    logic [IW-1:0] r_item;
    logic [IW-1:0] w_item_nxt;
    logic          r_sel_valid;
    logic          w_sel_valid_nxt;
    logic [PW-1:0] r_sel_page;
    logic [PW-1:0] w_sel_page_nxt;
    logic [IW-1:0] r_sel_item;
    logic [IW-1:0] w_sel_item_nxt;
    logic [IW-1:0] w_item_dec;
    logic [IW-1:0] w_item_inc;

    // Wrap arithmetic is modulo N_ITEMS, which need not be a power of two.
    assign w_item_dec = (r_item == '0)
                        ? ((WRAP != 0) ? IW'(N_ITEMS - 1) : r_item)
                        : r_item - 1'b1;
    assign w_item_inc = (r_item == IW'(N_ITEMS - 1))
                        ? ((WRAP != 0) ? '0 : r_item)
                        : r_item + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_page      <= '0;
            r_item      <= '0;
            r_sel_valid <= 1'b0;
            r_sel_page  <= '0;
            r_sel_item  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_page      <= w_page_nxt;
            r_item      <= w_item_nxt;
            r_sel_valid <= w_sel_valid_nxt;
            r_sel_page  <= w_sel_page_nxt;
            r_sel_item  <= w_sel_item_nxt;
        end
    end

    // NOTE: every signal driven here gets a hold-value default first, so no path
    // through the branches leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_page_nxt      = r_page;
        w_item_nxt      = r_item;
        w_sel_valid_nxt = r_sel_valid;
        w_sel_page_nxt  = r_sel_page;
        w_sel_item_nxt  = r_sel_item;

        if (back_to_main_menu_flag) begin
            // Overrides everything; key events this cycle are dropped.
            w_state_nxt     = ST_IDLE;
            w_page_nxt      = '0;
            w_item_nxt      = '0;
            w_sel_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ev_ent) begin
                        if (r_page == '0) begin
                            if (int'(r_item) + 1 < N_PAGES) begin
                                w_page_nxt = PW'(int'(r_item) + 1);
                                w_item_nxt = '0;
                            end else begin
                                w_sel_page_nxt  = r_page;
                                w_sel_item_nxt  = r_item;
                                w_sel_valid_nxt = 1'b1;
                                w_state_nxt     = ST_SELECT_WAIT;
                            end
                        end else if (r_item == IW'(N_ITEMS - 1)) begin
                            // Last item of a sub-page is "back": land on the
                            // main-page entry that opened this page.
                            w_page_nxt = '0;
                            w_item_nxt = IW'(int'(r_page) - 1);
                        end else begin
                            w_sel_page_nxt  = r_page;
                            w_sel_item_nxt  = r_item;
                            w_sel_valid_nxt = 1'b1;
                            w_state_nxt     = ST_SELECT_WAIT;
                        end
                    end else if (w_ev_up && !w_ev_dn) begin
                        w_item_nxt = w_item_dec;
                    end else if (w_ev_dn && !w_ev_up) begin
                        w_item_nxt = w_item_inc;
                    end
                end
                ST_SELECT_WAIT: begin
                    if (r_sel_valid && sel_ready) begin
                        w_sel_valid_nxt = 1'b0;
                        w_state_nxt     = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign menu_page = r_page;
    assign menu_item = r_item;
    assign sel_valid = r_sel_valid;
    assign sel_page  = r_sel_page;
    assign sel_item  = r_sel_item;

    // ------------------------------------------------------------------------
    // Frame-synchronous pointer position
    // ------------------------------------------------------------------------
    logic          r_vblnk_prev;
    logic [IW-1:0] r_disp_item;
    logic [10:0]   w_ptr_y;
    logic          w_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vblnk_prev <= 1'b0;
            r_disp_item  <= '0;
        end else begin
            r_vblnk_prev <= vblnk_in;
            if (vblnk_in && !r_vblnk_prev)
                r_disp_item <= r_item;
        end
    end

    // Geometry must keep the last item inside 11 bits; no saturation here.
    assign w_ptr_y = 11'(PTR_Y0 + int'(r_disp_item) * PTR_DY);

    // Compare in 12 bits so x0+w / y+h cannot wrap.
    assign w_hit = ({1'b0, hcount_in} >= 12'(PTR_X0))
                && ({1'b0, hcount_in} <  12'(PTR_X0 + PTR_W))
                && ({1'b0, vcount_in} >= {1'b0, w_ptr_y})
                && ({1'b0, vcount_in} <  ({1'b0, w_ptr_y} + 12'(PTR_H)))
                && !hblnk_in && !vblnk_in;

    // ------------------------------------------------------------------------
    // Overlay pipeline (2 clocks)
    // ------------------------------------------------------------------------
    logic [10:0] r_s1_hcount;
    logic [10:0] r_s1_vcount;
    logic        r_s1_hsync;
    logic        r_s1_vsync;
    logic        r_s1_hblnk;
    logic        r_s1_vblnk;
    logic [11:0] r_s1_rgb;
    logic        r_s1_hit;

    // NOTE: the stream registers are plain flops, so resetting them is cheap and
    // gives a clean all-zero output the instant rst asserts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_hcount <= '0;
            r_s1_vcount <= '0;
            r_s1_hsync  <= 1'b0;
            r_s1_vsync  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s1_rgb    <= '0;
            r_s1_hit    <= 1'b0;
            hcount_out  <= '0;
            vcount_out  <= '0;
            hsync_out   <= 1'b0;
            vsync_out   <= 1'b0;
            hblnk_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            rgb_out     <= '0;
        end else begin
            r_s1_hcount <= hcount_in;
            r_s1_vcount <= vcount_in;
            r_s1_hsync  <= hsync_in;
            r_s1_vsync  <= vsync_in;
            r_s1_hblnk  <= hblnk_in;
            r_s1_vblnk  <= vblnk_in;
            r_s1_rgb    <= rgb_in;
            r_s1_hit    <= w_hit;
            hcount_out  <= r_s1_hcount;
            vcount_out  <= r_s1_vcount;
            hsync_out   <= r_s1_hsync;
            vsync_out   <= r_s1_vsync;
            hblnk_out   <= r_s1_hblnk;
            vblnk_out   <= r_s1_vblnk;
            if (r_s1_hblnk || r_s1_vblnk)
                rgb_out <= '0;
            else if (r_s1_hit)
                rgb_out <= PTR_RGB;
            else
                rgb_out <= r_s1_rgb;
        end
    end

endmodule
